segment_mux_nx7: RTL

//  Time-multiplexed driver for an N-digit common-cathode/anode 7-segment display.

---
 rtl/segment_mux_nx7.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/segment_mux_nx7.sv
// Multiplexed N-digit hex 7-segment driver with PWM dimming, blanking,
// decimal points and leading-zero suppression, using a per-frame snapshot.
module segment_mux_nx7 #(
  parameter int DIGITS         = 4,
  parameter int SLOT_LOG2      = 7,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_en,
  input  logic [3:0]            brightness,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  frame_tick
);

  localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [SLOT_LOG2-1:0] CNT_MAX = '1;
  localparam logic [6:0]        SEG_OFF  = {7{SEG_ACTIVE_LOW}};
  localparam logic              DP_OFF   = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] DIG_OFF  = {DIGITS{DIG_ACTIVE_LOW}};

  logic [SLOT_LOG2-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [4*DIGITS-1:0]  snap_value_q, snap_value_d;
  logic [DIGITS-1:0]    snap_dp_q, snap_dp_d;
  logic [DIGITS-1:0]    snap_blank_q, snap_blank_d;
  logic                 snap_lz_q, snap_lz_d;
  logic [6:0]           seg_q, seg_d;
  logic                 seg_dp_q, seg_dp_d;
  logic [DIGITS-1:0]    dig_en_q, dig_en_d;
  logic                 frame_tick_q, frame_tick_d;

  logic [DIGITS-1:0]    nib_zero, upper_zero, lz_dark;
  logic                 load, dark, on_time;
  logic [3:0]           nibble;
  logic [6:0]           seg_lit;
  logic [DIGITS-1:0]    dig_lit;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'b0111111;
      4'h1:    hex7 = 7'b0000110;
      4'h2:    hex7 = 7'b1011011;
      4'h3:    hex7 = 7'b1001111;
      4'h4:    hex7 = 7'b1100110;
      4'h5:    hex7 = 7'b1101101;
      4'h6:    hex7 = 7'b1111101;
      4'h7:    hex7 = 7'b0000111;
      4'h8:    hex7 = 7'b1111111;
      4'h9:    hex7 = 7'b1100111;
      4'hA:    hex7 = 7'b1110111;
      4'hB:    hex7 = 7'b1111100;
      4'hC:    hex7 = 7'b0111001;
      4'hD:    hex7 = 7'b1011110;
      4'hE:    hex7 = 7'b1111001;
      default: hex7 = 7'b1110001;
    endcase
  endfunction

  // upper_zero[k]: nibbles k..DIGITS-1 of the snapshot are all zero
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_lz
      assign nib_zero[gi] = (snap_value_q[4*gi +: 4] == 4'h0);
      if (gi == DIGITS - 1) begin : g_top
        assign upper_zero[gi] = nib_zero[gi];
      end else begin : g_mid
        assign upper_zero[gi] = nib_zero[gi] & upper_zero[gi+1];
      end
      if (gi == 0) begin : g_d0
        assign lz_dark[gi] = 1'b0;
      end else begin : g_dn
        assign lz_dark[gi] = snap_lz_q & upper_zero[gi];
      end
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    load         = (idx_q == IDX_LAST) && (cnt_q == CNT_MAX);
    snap_value_d = load ? value : snap_value_q;
    snap_dp_d    = load ? dp    : snap_dp_q;
    snap_blank_d = load ? blank : snap_blank_q;
    snap_lz_d    = load ? lz_en : snap_lz_q;

    nibble  = snap_value_q[{idx_q, 2'b00} +: 4];
    dark    = snap_blank_q[idx_q] | lz_dark[idx_q];
    seg_lit = dark ? 7'h00 : hex7(nibble);

    // cnt==0 keeps every digit off so segment changes never ghost
    on_time = (cnt_q != '0) && (cnt_q[SLOT_LOG2-1 -: 4] <= brightness);
    dig_lit = '0;
    if (on_time) begin
      dig_lit[idx_q] = 1'b1;
    end

    seg_d        = seg_lit ^ SEG_OFF;
    seg_dp_d     = (snap_dp_q[idx_q] & ~dark) ^ DP_OFF;
    dig_en_d     = dig_lit ^ DIG_OFF;
    frame_tick_d = (idx_q == '0) && (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      snap_value_q <= '0;
      snap_dp_q    <= '0;
      snap_blank_q <= '0;
      snap_lz_q    <= 1'b0;
      seg_q        <= SEG_OFF;
      seg_dp_q     <= DP_OFF;
      dig_en_q     <= DIG_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_value_q <= snap_value_d;
      snap_dp_q    <= snap_dp_d;
      snap_blank_q <= snap_blank_d;
      snap_lz_q    <= snap_lz_d;
      seg_q        <= seg_d;
      seg_dp_q     <= seg_dp_d;
      dig_en_q     <= dig_en_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign seg_dp     = seg_dp_q;
  assign dig_en     = dig_en_q;
  assign frame_tick = frame_tick_q;

endmodule
